// File: rtl/uart8_receiver.sv
// ---------------------------------------------------------------------------
// uart8_receiver
//
// Oversampling UART receiver. The serial line is synchronised, the start bit
// is qualified at its midpoint, and every data bit and the stop bit are
// sampled once per bit period at the bit centre. A good frame updates `out`
// and pulses `done`. A low stop bit pulses `err` and then waits for the line
// to return high, so a break condition cannot retrigger reception.
//
// Parameters
//   DATA_BITS   data bits per frame (LSB first)
//   OVERSAMPLE  clk cycles per bit period (even, >= 4)
//
// Ports
//   clk   receive sample clock, OVERSAMPLE x baud rate
//   rst   synchronous, active-high reset
//   en    receiver enable; low holds the receiver idle
//   in    serial line, idle high
//   out   last correctly received data word
//   done  one-cycle pulse: valid frame received, out updated
//   busy  high while the FSM is in any state other than IDLE
//   err   one-cycle pulse: framing error (stop bit sampled low)
// ---------------------------------------------------------------------------
module uart8_receiver #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 in,
  output logic [DATA_BITS-1:0] out,
  output logic                 done,
  output logic                 busy,
  output logic                 err
);

  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam int IDX_W = $clog2(DATA_BITS + 1);
  localparam int SEL_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_e;

  state_e                 state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [IDX_W-1:0]       bit_idx_q;
  logic [DATA_BITS-1:0]   data_q;
  logic [DATA_BITS-1:0]   data_d;
  logic [DATA_BITS-1:0]   out_q;
  logic                   done_q;
  logic                   err_q;
  logic                   busy_q;
  logic                   sync1_q;
  logic                   sync2_q;
  logic                   in_s;
  logic [SEL_W-1:0]       bit_sel;

  // Two-flop synchroniser; resets to the idle (high) line level so that
  // leaving reset never looks like a start bit.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of the others (sync2_q gets the old sync1_q).
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= in;
      sync2_q <= sync1_q;
    end
  end

  assign in_s    = sync2_q;
  assign bit_sel = bit_idx_q[SEL_W-1:0];

  // Data register with the current sample written at position bit_idx.
  always_comb begin
    // NOTE: the full default first keeps this purely combinational; a
    // partially assigned vector here would infer a latch.
    data_d          = data_q;
    data_d[bit_sel] = in_s;
  end

  // Receive FSM. busy_q is written alongside every state change so that it
  // is always the registered decode (state != IDLE).
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the data register is reset along with the control state; it is
      // a handful of flops, not a RAM, and keeps out deterministic.
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      data_q    <= '0;
      out_q     <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else if (!en) begin
      // Disabled: abandon any partial frame, keep out.
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (!in_s) begin
            state_q <= START;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end

        // Re-check the line half a bit later; a high level there was a glitch.
        START: begin
          if (cnt_q == CNT_HALF) begin
            cnt_q <= '0;
            if (!in_s) begin
              state_q   <= DATA;
              bit_idx_q <= '0;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        // From the start-bit midpoint, each full period lands on a bit centre.
        DATA: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q     <= '0;
            data_q    <= data_d;
            bit_idx_q <= bit_idx_q + 1'b1;
            if (bit_idx_q == IDX_LAST) begin
              state_q <= STOP;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        // Decision at mid stop bit, so a start bit directly after the stop
        // bit finds the FSM already in IDLE.
        STOP: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q <= '0;
            if (in_s) begin
              out_q   <= data_q;
              done_q  <= 1'b1;
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end else begin
              err_q   <= 1'b1;
              state_q <= WAIT_HIGH;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        WAIT_HIGH: begin
          if (in_s) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end

        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign out  = out_q;
  assign done = done_q;
  assign err  = err_q;
  assign busy = busy_q;

endmodule
